// File: rtl/mfu_acc.sv
// Per-lane accumulator for packed mFU products: 1x16b, 2x8b or 4x4b signed lanes.
// Optional macro MFU_ACC_SAT_EN makes each lane add saturate; without it, lane adds wrap.
module mfu_acc #(
    parameter int ACC_W = 20
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [15:0]        in_p,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_mode,
    output logic [4*ACC_W-1:0] out_sum,
    output logic [7:0]         out_count,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [3:0][ACC_W-1:0]   r_acc;
    logic [7:0]              r_count;
    logic                    r_err;

    logic [3:0][ACC_W-1:0]   w_lane;
    logic [3:0][ACC_W-1:0]   w_sum;

    always_comb begin
        w_lane = '0;
        case (in_mode)
            2'b01: w_lane[0] = ACC_W'($signed(in_p));
            2'b10: begin
                w_lane[0] = ACC_W'($signed(in_p[7:0]));
                w_lane[1] = ACC_W'($signed(in_p[15:8]));
            end
            2'b11: begin
                w_lane[0] = ACC_W'($signed(in_p[3:0]));
                w_lane[1] = ACC_W'($signed(in_p[7:4]));
                w_lane[2] = ACC_W'($signed(in_p[11:8]));
                w_lane[3] = ACC_W'($signed(in_p[15:12]));
            end
            default: w_lane = '0;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
`ifdef MFU_ACC_SAT_EN
        // One guard bit: overflow shows as disagreement between the top two bits.
        logic [ACC_W:0] w_wide;
        assign w_wide   = {r_acc[k][ACC_W-1], r_acc[k]} + {w_lane[k][ACC_W-1], w_lane[k]};
        assign w_sum[k] = (w_wide[ACC_W] == w_wide[ACC_W-1]) ? w_wide[ACC_W-1:0] :
                          w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                          {1'b0, {(ACC_W-1){1'b1}}};
`else
        assign w_sum[k] = r_acc[k] + w_lane[k];
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_acc   <= '0;
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // NOOP beats never open a group, even with in_last set.
                    if (in_valid && in_mode != 2'b00) begin
                        r_mode  <= in_mode;
                        r_acc   <= w_lane;
                        r_count <= 8'd1;
                        r_state <= in_last ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        if (in_mode == r_mode) begin
                            r_acc <= w_sum;
                            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                        end else if (in_mode != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (in_last) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_mode  <= 2'b00;
                        r_acc   <= '0;
                        r_count <= 8'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign out_mode  = r_mode;
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_mfu_acc.sv
// Scoreboard bench for mfu_acc: directed beats push expected group results, a monitor checks handoffs.
module tb_mfu_acc;

    localparam int W = 17;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_mode = 2'b00;
    logic [15:0]    in_p = 16'h0000;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [1:0]     out_mode;
    logic [4*W-1:0] out_sum;
    logic [7:0]     out_count;
    logic           err;

    mfu_acc #(.ACC_W(W)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_p(in_p), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_sum(out_sum), .out_count(out_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0][31:0] sum;
        logic [7:0]       count;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic [1:0] m, input int s0, input int s1,
                                input int s2, input int s3, input int c, input logic e);
        exp_t r;
        r.mode   = m;
        r.sum[0] = s0;
        r.sum[1] = s1;
        r.sum[2] = s2;
        r.sum[3] = s3;
        r.count  = 8'(c);
        r.err    = e;
        return r;
    endfunction

    function automatic int lane(input int k);
        logic signed [W-1:0] v;
        v = out_sum[k*W +: W];
        return int'(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the handoff cycle is where the consumer sees the result.
    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got count %0d expected no result", out_count);
            end else begin
                mon_e = sb.pop_front();
                for (int k = 0; k < 4; k++)
                    chk($sformatf("sb_lane%0d", k), lane(k), int'($signed(mon_e.sum[k])));
                chk("sb_count", int'(out_count), int'(mon_e.count));
                chk("sb_mode", int'(out_mode), int'(mon_e.mode));
                chk("sb_err", int'(err), int'(mon_e.err));
            end
        end
    end

    task automatic beat(input logic [1:0] m, input logic [15:0] p, input logic l);
        in_valid = 1'b1;
        in_mode  = m;
        in_p     = p;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'b00;
        in_last  = 1'b0;
    endtask

    task automatic handoff(input string name);
        chk({name, "_out_valid"}, int'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
        #1;
        out_ready = 1'b0;
        chk({name, "_idle_valid"}, int'(out_valid), 0);
        chk({name, "_idle_ready"}, int'(in_ready), 1);
        chk({name, "_idle_count"}, int'(out_count), 0);
        chk({name, "_idle_err"}, int'(err), 0);
        chk({name, "_idle_lane0"}, lane(0), 0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mode", int'(out_mode), 0);
        chk("rst_sum_zero", int'(out_sum == '0), 1);
        chk("rst_count", int'(out_count), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Mode 01: -10 + 20
        beat(2'b01, 16'hFFF6, 1'b0);
        sb.push_back(mk(2'b01, 10, 0, 0, 0, 2, 1'b0));
        beat(2'b01, 16'h0014, 1'b1);
        handoff("m01");

        // Mode 10 with a 3-cycle stall and a beat offered while not ready
        sb.push_back(mk(2'b10, -128, 127, 0, 0, 1, 1'b0));
        beat(2'b10, 16'h7F80, 1'b1);
        in_valid = 1'b1;
        in_mode  = 2'b10;
        in_p     = 16'h0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_lane0", lane(0), -128);
            chk("stall_lane1", lane(1), 127);
            chk("stall_count", int'(out_count), 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'b00;
        handoff("m10");

        // Mode 11 nibbles
        sb.push_back(mk(2'b11, 7, 1, -1, -8, 1, 1'b0));
        beat(2'b11, 16'h8F17, 1'b1);
        handoff("m11");

        // Mode mismatch is dropped and flagged
        beat(2'b10, 16'h0101, 1'b0);
        beat(2'b11, 16'h1234, 1'b0);
        chk("mismatch_err_set", int'(err), 1);
        sb.push_back(mk(2'b10, 2, 2, 0, 0, 2, 1'b1));
        beat(2'b10, 16'h0101, 1'b1);
        handoff("mismatch");

        // Lane overflow behaviour at ACC_W=17
        beat(2'b01, 16'h7FFF, 1'b0);
        beat(2'b01, 16'h7FFF, 1'b0);
`ifdef MFU_ACC_SAT_EN
        sb.push_back(mk(2'b01, 65535, 0, 0, 0, 3, 1'b0));
`else
        sb.push_back(mk(2'b01, -32771, 0, 0, 0, 3, 1'b0));
`endif
        beat(2'b01, 16'h7FFF, 1'b1);
        handoff("ovf");

        // NOOP beats: ignored in IDLE, close the group in ACC without adding
        beat(2'b00, 16'h1234, 1'b1);
        chk("idle_noop_valid", int'(out_valid), 0);
        chk("idle_noop_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        chk("idle_noop_valid2", int'(out_valid), 0);
        beat(2'b01, 16'h0005, 1'b0);
        beat(2'b00, 16'hFFFF, 1'b0);
        chk("acc_noop_count", int'(out_count), 1);
        sb.push_back(mk(2'b01, 5, 0, 0, 0, 1, 1'b0));
        beat(2'b00, 16'hFFFF, 1'b1);
        handoff("noop");

        // Count saturates at 255 while sums keep growing
        for (int i = 0; i < 299; i++) beat(2'b11, 16'h0001, 1'b0);
        sb.push_back(mk(2'b11, 300, 0, 0, 0, 255, 1'b0));
        beat(2'b11, 16'h0001, 1'b1);
        handoff("cnt_sat");

        // Asynchronous reset mid-group
        beat(2'b01, 16'h0003, 1'b0);
        beat(2'b01, 16'h0004, 1'b0);
        chk("pre_rst_count", int'(out_count), 2);
        nrst = 1'b0;
        #1;
        chk("async_rst_count", int'(out_count), 0);
        chk("async_rst_sum", int'(out_sum == '0), 1);
        chk("async_rst_mode", int'(out_mode), 0);
        chk("async_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(2'b01, 5, 0, 0, 0, 1, 1'b0));
        beat(2'b01, 16'h0005, 1'b1);
        handoff("post_rst");

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
